// File: rtl/sha256_chain_ctrl.sv
// Multi-block SHA-256 sequencer: issues one padded block at a time to the transform core and accumulates the chaining value.
// Optional watchdog on the core result is enabled with `define SHA256_CTRL_WD_EN.
//
// state | meaning
// IDLE  | ready for the first block of a message, H = H0
// ISSUE | ready for the next block of a message, H = running chain value
// WAIT  | one block outstanding in the core, waiting for its result
// OUT   | digest presented on the source until accepted
module sha256_chain_ctrl #(
   parameter int CORE_LAT = 65,
   parameter int WD_SLACK = 16
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [511:0] s_tdata,
   input  logic         s_tvalid,
   input  logic         s_tlast,
   output logic         s_tready,
   output logic         core_valid_o,
   output logic [511:0] core_chunk_o,
   output logic [255:0] core_state_o,
   input  logic [255:0] core_hash_i,
   input  logic         core_valid_i,
   output logic [511:0] m_tdata,
   output logic [63:0]  m_tkeep,
   output logic         m_tvalid,
   output logic         m_tlast,
   input  logic         m_tready,
   output logic         err_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   localparam logic [255:0] H0 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                  32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   state_t       state_q, state_d;
   logic [255:0] h_q;
   logic [255:0] h_sum;
   logic         last_q;
   logic         s_hs;
   logic         m_hs;
   logic         wd_fire;

   assign s_hs    = s_tvalid && s_tready;
   assign m_hs    = m_tvalid && m_tready;
   assign m_tkeep = 64'h0000_0000_ffff_ffff;
   assign m_tlast = m_tvalid;

`ifdef SHA256_CTRL_WD_EN
   localparam int WD_LIMIT = CORE_LAT + WD_SLACK;
   localparam int WD_W     = ($clog2(WD_LIMIT + 1) > 8) ? $clog2(WD_LIMIT + 1) : 8;
   localparam logic [WD_W-1:0] WD_TC = WD_W'(WD_LIMIT - 1);

   logic [WD_W-1:0] wd_cnt;

   // Counts cycles spent in WAIT; fires on the edge where it would reach the limit.
   always_ff @(posedge aclk) begin
      if (!aresetn || state_q != WAIT) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_TC) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_fire = (state_q == WAIT) && !core_valid_i && (wd_cnt == WD_TC);
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         h_sum[32*i +: 32] = h_q[32*i +: 32] + core_hash_i[32*i +: 32];
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ISSUE: if (s_hs) state_d = WAIT;
         WAIT: begin
            if (core_valid_i) begin
               state_d = last_q ? OUT : ISSUE;
            end else if (wd_fire) begin
               state_d = IDLE;
            end
         end
         OUT:         if (m_hs) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         h_q          <= H0;
         last_q       <= 1'b0;
         s_tready     <= 1'b0;
         core_valid_o <= 1'b0;
         core_chunk_o <= '0;
         core_state_o <= H0;
         m_tvalid     <= 1'b0;
         m_tdata      <= '0;
         err_o        <= 1'b0;
      end else begin
         core_valid_o <= 1'b0;
         if (core_valid_i && state_q != WAIT) begin
            err_o <= 1'b1;
         end
         case (state_q)
            IDLE, ISSUE: begin
               if (s_hs) begin
                  core_chunk_o <= s_tdata;
                  last_q       <= s_tlast;
                  s_tready     <= 1'b0;
                  core_valid_o <= 1'b1;
                  core_state_o <= h_q;
               end else begin
                  s_tready <= 1'b1;
               end
            end
            WAIT: begin
               if (core_valid_i) begin
                  h_q <= h_sum;
               end else if (wd_fire) begin
                  err_o  <= 1'b1;
                  h_q    <= H0;
                  last_q <= 1'b0;
               end
            end
            OUT: begin
               // m_tdata is rewritten from an unchanging H, so it stays stable under backpressure.
               if (m_hs) begin
                  m_tvalid <= 1'b0;
                  h_q      <= H0;
                  last_q   <= 1'b0;
               end else begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= {256'b0, h_q};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
